// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised serial pattern detector: KMP fallback
// and next-state constant functions, evaluated at elaboration only.
package seq_det_pkg;

  localparam int SEQ_DET_MAX_LEN = 32;

  function automatic int seq_det_sw(input int len);
    return $clog2(len + 1);
  endfunction

  // Bit idx of the pattern in arrival order (idx 0 is the MSB, received first).
  function automatic logic seq_det_bit(input logic [31:0] pattern, input int len, input int idx);
    logic [31:0] shifted;
    shifted = pattern >> (len - 1 - idx);
    return shifted[0];
  endfunction

  // Longest proper prefix of the first k pattern bits that is also a suffix of them.
  function automatic int seq_det_fail(input logic [31:0] pattern, input int len, input int k);
    int   best;
    logic same;
    best = 0;
    for (int j = 1; j < k; j++) begin
      same = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (seq_det_bit(pattern, len, i) != seq_det_bit(pattern, len, k - j + i)) same = 1'b0;
      end
      if (same) best = j;
    end
    return best;
  endfunction

  function automatic int seq_det_next(input logic [31:0] pattern, input int len, input int k,
                                      input logic b);
    int   s;
    logic done;
    s    = k;
    done = 1'b0;
    for (int it = 0; it <= SEQ_DET_MAX_LEN; it++) begin
      if (!done) begin
        if (seq_det_bit(pattern, len, s) == b) begin
          s    = s + 1;
          done = 1'b1;
        end else if (s == 0) begin
          done = 1'b1;
        end else begin
          s = seq_det_fail(pattern, len, s);
        end
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear that wins over increment.
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial pattern detector with overlapped/non-overlapped matching and a
// saturating match counter. Optional idle timeout via SEQ_DET_TIMEOUT_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8,
  parameter int                 TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            din_valid,
  input  logic                            din,
  input  logic                            clr_cnt,
  output logic                            dout,
  output logic [CNT_W-1:0]                match_cnt,
  output logic [seq_det_sw(PAT_LEN)-1:0]  progress,
  output logic                            timeout
);

  localparam int          SW         = seq_det_sw(PAT_LEN);
  localparam logic [31:0] PAT32      = 32'(PATTERN);
  localparam int          MATCH_BASE = (OVERLAP != 0) ? seq_det_fail(PAT32, PAT_LEN, PAT_LEN) : 0;

  // The state is the number of pattern bits currently matched; PAT_LEN is MATCH.
  logic [SW-1:0] state_q, state_d;
  logic          dout_q;
  logic          timeoutHit;
  logic          matchInc;
  logic [SW-1:0] nextOnZero [PAT_LEN+1];
  logic [SW-1:0] nextOnOne  [PAT_LEN+1];

  for (genvar k = 0; k <= PAT_LEN; k++) begin : g_next
    localparam int            BASE = (k == PAT_LEN) ? MATCH_BASE : k;
    localparam logic [SW-1:0] N0   = SW'(seq_det_next(PAT32, PAT_LEN, BASE, 1'b0));
    localparam logic [SW-1:0] N1   = SW'(seq_det_next(PAT32, PAT_LEN, BASE, 1'b1));
    assign nextOnZero[k] = N0;
    assign nextOnOne[k]  = N1;
  end

  always_comb begin
    state_d = state_q;
    if (din_valid) begin
      state_d = din ? nextOnOne[state_q] : nextOnZero[state_q];
    end else if (timeoutHit) begin
      state_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= (state_d == SW'(PAT_LEN));
    end
  end

  assign matchInc = din_valid && (state_d == SW'(PAT_LEN));

  seq_det_sat_cnt #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (matchInc),
    .clr_i (clr_cnt),
    .cnt_o (match_cnt)
  );

`ifdef SEQ_DET_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idleCnt;
  logic              idleInc;
  logic              idleClr;
  logic              timeout_q;

  // A valid bit always restarts the idle count, so it takes priority over timeout.
  assign idleInc    = !din_valid && (state_q != '0);
  assign timeoutHit = idleInc && (idleCnt == IDLE_W'(TIMEOUT - 1));
  assign idleClr    = !idleInc || timeoutHit;

  seq_det_sat_cnt #(.W(IDLE_W)) u_idle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (idleInc),
    .clr_i (idleClr),
    .cnt_o (idleCnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeoutHit;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeoutHit = 1'b0;
  assign timeout    = 1'b0;
`endif

  assign dout     = dout_q;
  assign progress = state_q;

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Moore-style serial pattern detector, successor to the fixed 3-state detector.
- Detects any PAT_LEN-bit pattern on a 1-bit stream qualified by din_valid.
- Supports overlapped or non-overlapped matching.
- Counts matches in a saturating counter.
- Sits behind serial receive logic as a framing/sync-word detector.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..32.
PATTERN, 4'b1011, [PAT_LEN-1:0] target; MSB is the first bit received.
OVERLAP, 1, 1 = overlapped matching (KMP fallback after a match); 0 = restart from empty after a match.
CNT_W, 8, match counter width.
TIMEOUT, 16, idle-cycle limit; used only when SEQ_DET_TIMEOUT_EN is defined.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
din_valid  in  1  qualifies din; a bit is consumed only on edges where din_valid=1
din  in  1  serial data bit
clr_cnt  in  1  synchronous clear of match_cnt
dout  out  1  Moore match flag; high while state == MATCH
match_cnt  out  CNT_W  saturating count of MATCH entries
progress  out  SW  current state (count of pattern bits matched); SW = $clog2(PAT_LEN+1)
timeout  out  1  one-cycle idle-timeout pulse; tied 0 when the feature is absent

Behaviour:
- Reset (rst=1 at an edge):
  - state = 0 (IDLE), dout = 0, match_cnt = 0, progress = 0, timeout = 0.
  - rst overrides every other input in the same cycle.
- States 0..PAT_LEN. State k means the last k consumed bits equal PATTERN[PAT_LEN-1 -: k]. State PAT_LEN is MATCH.
- dout is decoded from the registered state only; it never depends combinationally on din. Latency: dout rises in the cycle after the edge that consumes the final pattern bit.
- din_valid=0: state, dout and match_cnt hold. dout stays high through stalls while in MATCH.
- din_valid=1, state k < PAT_LEN:
  - if din == PATTERN[PAT_LEN-1-k], next state = k+1;
  - otherwise next state = KMP fallback, i.e. the longest j ≤ k such that the last j received bits, including din, equal the pattern prefix of length j.
- din_valid=1, state MATCH:
  - OVERLAP=1: evaluate din from state fail(PAT_LEN), the longest proper prefix-suffix length, so a new match can complete in fewer than PAT_LEN further bits.
  - OVERLAP=0: evaluate din from state 0.
- Fallback table: elaboration-time constant computed from PATTERN by a constant function. No runtime pattern logic.
- match_cnt:
  - increments by 1 on each edge where next state = MATCH and din_valid=1, including MATCH→MATCH for patterns such as 1111 with overlap;
  - saturates at 2^CNT_W-1;
  - if clr_cnt is asserted in the same cycle as an increment, clear wins and the result is 0.
- Reset mid-pattern discards all progress; the following bit is evaluated from state 0.

Optional Feature:
SEQ_DET_TIMEOUT_EN
- Defined:
  - An idle counter counts consecutive din_valid=0 cycles while state != 0.
  - When the count reaches TIMEOUT, state forces to 0 at that edge (dout drops if it was in MATCH) and timeout pulses high for one cycle.
  - Any valid bit resets the idle counter. If din_valid=1 in the same cycle, the valid bit takes priority over the timeout.
- Not defined: no idle counter, timeout tied 0, state holds indefinitely.

Decomposition:
- Package seq_det_pkg:
  - constant function seq_det_fail(pattern, len, k), returning the KMP fallback state;
  - function seq_det_next(pattern, len, k, bit);
  - localparam helper for SW.
- One sub-module, seq_det_sat_cnt: CNT_W saturating counter with inc/clr and clear priority, reused for match_cnt and the idle counter.

Test Plan:
- Reset: rst=1 for 2 cycles, then streaming 1011 → dout=0, match_cnt=0 during reset; match_cnt=1 after release and the full pattern.
- Overlap, PATTERN=1011, OVERLAP=1, stream 1,0,1,1,0,1,1 → dout high after bits 4 and 7; match_cnt=2.
- Non-overlap, same stream, OVERLAP=0 → a single dout assertion after bit 4; match_cnt=1.
- Stall: insert din_valid=0 gaps of 3 cycles between pattern bits → same matches as the gapless stream; progress is held across each gap.
- Counter edges: CNT_W=2 with 5 matches → match_cnt saturates at 3. Assert clr_cnt on a match edge → match_cnt=0.
- Timeout (macro defined, TIMEOUT=4): bits 1,0,1, then 4 idle cycles → timeout pulses once, progress=0; a following single 1 does not produce a match.
